// File: rtl/wb_intc.sv
// Wishbone interrupt controller: per-source enable, edge/level mode, polarity and pending latch,
// combined into one registered interrupt line plus a priority-encoded source index.
module wb_intc #(
  parameter int unsigned NUM_IRQ = 32,
  parameter int unsigned SYNC_EN = 1
) (
  input  logic               clk_i,
  input  logic               nrst_i,
  input  logic [4:0]         wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  input  logic [3:0]         wb_sel_i,
  input  logic               wb_we_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               irq_o,
  output logic [4:0]         irq_id_o,
  output logic               irq_valid_o
);

  localparam logic [31:0] Mask = 32'((64'h1 << NUM_IRQ) - 64'h1);

  localparam logic [2:0] AddrStatus   = 3'd0;
  localparam logic [2:0] AddrPending  = 3'd1;
  localparam logic [2:0] AddrEnable   = 3'd2;
  localparam logic [2:0] AddrMode     = 3'd3;
  localparam logic [2:0] AddrPolarity = 3'd4;
  localparam logic [2:0] AddrVector   = 3'd5;
  localparam logic [2:0] AddrSet      = 3'd6;
  localparam logic [2:0] AddrUnmapped = 3'd7;

  logic [31:0] pending_q, enable_q, mode_q, polarity_q, prev_q;
  logic [31:0] pending_d, enable_d, mode_d, polarity_d;
  logic [31:0] irq_ext, irq_sync, adj, edge_det, act;
  logic [31:0] byte_mask, wdata, w1c, set_bits, rdata;
  logic        ack_q, err_q, irq_q, valid_q;
  logic [31:0] dat_q;
  logic [4:0]  id_q, id_d;
  logic        req, wr;
  logic [2:0]  reg_sel;
  logic        unused_adr;

  assign unused_adr = ^wb_adr_i[1:0];
  assign irq_ext    = Mask & 32'(irq_i);

  if (SYNC_EN != 0) begin : g_sync
    logic [31:0] sync1_q, sync2_q;
    always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
        sync1_q <= '0;
        sync2_q <= '0;
      end else begin
        sync1_q <= irq_ext;
        sync2_q <= sync1_q;
      end
    end
    assign irq_sync = sync2_q;
  end else begin : g_nosync
    assign irq_sync = irq_ext;
  end

  assign adj      = (irq_sync ^ ~polarity_q) & Mask;
  assign edge_det = adj & ~prev_q;
  assign act      = pending_q & enable_q;

  // A response is only started while no ack/err is showing, so a held strobe alternates.
  assign req       = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
  assign wr        = req & wb_we_i;
  assign reg_sel   = wb_adr_i[4:2];
  assign byte_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign wdata     = wb_dat_i & byte_mask & Mask;
  assign w1c       = (wr && reg_sel == AddrPending) ? wdata : '0;
  assign set_bits  = (wr && reg_sel == AddrSet) ? wdata : '0;

  always_comb begin
    enable_d   = enable_q;
    mode_d     = mode_q;
    polarity_d = polarity_q;
    if (wr) begin
      case (reg_sel)
        AddrEnable:   enable_d   = (enable_q & ~byte_mask) | wdata;
        AddrMode:     mode_d     = (mode_q & ~byte_mask) | wdata;
        AddrPolarity: polarity_d = (polarity_q & ~byte_mask) | wdata;
        default:      ;
      endcase
    end
    // Set beats clear in edge mode; level-mode bits simply track the input.
    pending_d = ((mode_q & ((pending_q & ~w1c) | edge_det | set_bits)) | (~mode_q & adj)) & Mask;
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      AddrStatus:   rdata = adj;
      AddrPending:  rdata = pending_q;
      AddrEnable:   rdata = enable_q;
      AddrMode:     rdata = mode_q;
      AddrPolarity: rdata = polarity_q;
      AddrVector:   rdata = {valid_q, 26'd0, id_q};
      default:      rdata = '0;
    endcase
  end

  always_comb begin
    id_d = '0;
    for (int i = 31; i >= 0; i--) begin
      if (act[i]) id_d = 5'(i);
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      dat_q      <= '0;
      pending_q  <= '0;
      enable_q   <= '0;
      mode_q     <= '0;
      polarity_q <= Mask;
      prev_q     <= '0;
      irq_q      <= 1'b0;
      id_q       <= '0;
      valid_q    <= 1'b0;
    end else begin
      ack_q      <= req & (reg_sel != AddrUnmapped);
      err_q      <= req & (reg_sel == AddrUnmapped);
      dat_q      <= (req && !wb_we_i) ? rdata : '0;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      mode_q     <= mode_d;
      polarity_q <= polarity_d;
      prev_q     <= adj;
      irq_q      <= |act;
      id_q       <= id_d;
      valid_q    <= |act;
    end
  end

  assign wb_ack_o    = ack_q;
  assign wb_err_o    = err_q;
  assign wb_dat_o    = dat_q;
  assign irq_o       = irq_q;
  assign irq_id_o    = id_q;
  assign irq_valid_o = valid_q;

endmodule
